// File: rtl/game_pkg.sv
// Shared phase encoding, datapath widths and a saturating-add helper for the
// round controller and its score counter.
package game_pkg;

    localparam int         FRAME_W = 12;
    localparam int         SCORE_W = 11;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_READY = 3'd1,
        PH_PLAY  = 3'd2,
        PH_HOLD  = 3'd3,
        PH_OVER  = 3'd4
    } phase_t;

    function automatic logic [FRAME_W-1:0] frame_sat_add(
        input logic [FRAME_W-1:0] a,
        input logic [FRAME_W-1:0] b,
        input logic [FRAME_W-1:0] lim
    );
        logic [FRAME_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[FRAME_W-1:0];
    endfunction

endpackage

// File: rtl/bcd_sat_counter.sv
// Two-digit BCD score counter with a binary mirror; increments stop at MAX so
// the digits and the binary value always describe the same number.
module bcd_sat_counter
    import game_pkg::*;
#(
    parameter int MAX = 99
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [3:0]         ones_o,
    output logic [3:0]         tens_o,
    output logic [SCORE_W-1:0] bin_o,
    output logic               sat_o
);

    logic [3:0]         ones_q, ones_d;
    logic [3:0]         tens_q, tens_d;
    logic [SCORE_W-1:0] bin_q, bin_d;

    assign sat_o  = (bin_q >= SCORE_W'(MAX));
    assign ones_o = ones_q;
    assign tens_o = tens_q;
    assign bin_o  = bin_q;

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        bin_d  = bin_q;
        if (clr_i) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
            bin_d  = '0;
        end else if (inc_i && !sat_o) begin
            bin_d = bin_q + 1'b1;
            if (ones_q == BCD_MAX) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
            bin_q  <= '0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
            bin_q  <= bin_d;
        end
    end

endmodule

// File: rtl/round_controller.sv
// Per-round sequencer: countdown, timed play, miss hold-off and game over, plus
// score/lives/timer datapath. ROUND_TIME_BONUS_EN adds time per accepted hit.
module round_controller
    import game_pkg::*;
#(
    parameter int READY_FRAMES      = 120,
    parameter int ROUND_FRAMES      = 3600,
    parameter int MISS_HOLD_FRAMES  = 30,
    parameter int LIVES             = 3,
    parameter int SCORE_MAX         = 99,
    parameter int TIME_BONUS_FRAMES = 60
) (
    input  logic               frame_clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               run_i,
    input  logic               pause_i,
    input  logic               hit_target_i,
    input  logic               hit_floor_i,
    output logic [SCORE_W-1:0] score_o,
    output logic [3:0]         hex_lo_o,
    output logic [3:0]         hex_hi_o,
    output logic [2:0]         lives_o,
    output logic [FRAME_W-1:0] time_left_o,
    output logic [2:0]         phase_o,
    output logic               playing_o,
    output logic               game_over_o,
    output logic               hit_accept_o
);

    phase_t             phase_q, phase_d;
    logic [FRAME_W-1:0] ptimer_q, ptimer_d;
    logic [FRAME_W-1:0] tleft_q, tleft_d, tleft_dec;
    logic [2:0]         lives_q, lives_d;
    logic               prev_hit_q, prev_floor_q;
    logic               hit_accept_q, hit_accept_d;
    logic               playing_q, over_q;
    logic               hit_edge, miss_edge, score_sat, score_inc, score_clr, to_over;

    assign hit_edge  = hit_target_i & ~prev_hit_q;
    assign miss_edge = hit_floor_i & ~prev_floor_q;
    assign tleft_dec = tleft_q - 1'b1;

    bcd_sat_counter #(
        .MAX (SCORE_MAX)
    ) u_score (
        .clk_i  (frame_clk_i),
        .rst_i  (reset_i),
        .clr_i  (score_clr),
        .inc_i  (score_inc),
        .ones_o (hex_lo_o),
        .tens_o (hex_hi_o),
        .bin_o  (score_o),
        .sat_o  (score_sat)
    );

    always_comb begin
        phase_d      = phase_q;
        ptimer_d     = ptimer_q;
        tleft_d      = tleft_q;
        lives_d      = lives_q;
        hit_accept_d = 1'b0;
        score_inc    = 1'b0;
        score_clr    = 1'b0;
        to_over      = 1'b0;
        if (clear_i) begin
            phase_d   = PH_IDLE;
            ptimer_d  = '0;
            tleft_d   = '0;
            lives_d   = 3'd0;
            score_clr = 1'b1;
        end else if (!pause_i) begin
            case (phase_q)
                PH_IDLE: begin
                    if (run_i) begin
                        phase_d  = PH_READY;
                        ptimer_d = FRAME_W'(READY_FRAMES);
                        lives_d  = 3'(LIVES);
                    end
                end
                PH_READY: begin
                    if (!run_i) begin
                        phase_d = PH_IDLE;
                    end else begin
                        ptimer_d = ptimer_q - 1'b1;
                        if (ptimer_q == FRAME_W'(1)) begin
                            phase_d = PH_PLAY;
                            tleft_d = FRAME_W'(ROUND_FRAMES);
                        end
                    end
                end
                PH_PLAY: begin
                    if (!run_i) begin
                        phase_d = PH_IDLE;
                    end else begin
                        // The hit is scored before the miss/expiry outcome of the same tick.
                        score_inc    = hit_edge & ~score_sat;
                        hit_accept_d = score_inc;
                        tleft_d      = tleft_dec;
                        if (miss_edge) begin
                            lives_d = lives_q - 1'b1;
                        end
                        to_over = (tleft_q == FRAME_W'(1)) | (miss_edge & (lives_q == 3'd1));
                        if (to_over) begin
                            phase_d = PH_OVER;
                        end else if (miss_edge) begin
                            phase_d  = PH_HOLD;
                            ptimer_d = FRAME_W'(MISS_HOLD_FRAMES);
                        end
`ifdef ROUND_TIME_BONUS_EN
                        if (score_inc && !to_over) begin
                            tleft_d = frame_sat_add(tleft_dec, FRAME_W'(TIME_BONUS_FRAMES),
                                                    FRAME_W'(ROUND_FRAMES));
                        end
`else
`endif
                    end
                end
                PH_HOLD: begin
                    if (!run_i) begin
                        phase_d = PH_IDLE;
                    end else begin
                        ptimer_d = ptimer_q - 1'b1;
                        if (ptimer_q == FRAME_W'(1)) begin
                            phase_d = PH_PLAY;
                        end
                    end
                end
                PH_OVER: begin
                    if (!run_i) begin
                        phase_d = PH_IDLE;
                    end
                end
                default: phase_d = PH_IDLE;
            endcase
        end
    end

    always_ff @(posedge frame_clk_i or posedge reset_i) begin
        if (reset_i) begin
            phase_q      <= PH_IDLE;
            ptimer_q     <= '0;
            tleft_q      <= '0;
            lives_q      <= 3'd0;
            prev_hit_q   <= 1'b0;
            prev_floor_q <= 1'b0;
            hit_accept_q <= 1'b0;
            playing_q    <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            ptimer_q     <= ptimer_d;
            tleft_q      <= tleft_d;
            lives_q      <= lives_d;
            prev_hit_q   <= hit_target_i;
            prev_floor_q <= hit_floor_i;
            hit_accept_q <= hit_accept_d;
            playing_q    <= (phase_d == PH_PLAY);
            over_q       <= (phase_d == PH_OVER);
        end
    end

    assign lives_o      = lives_q;
    assign time_left_o  = tleft_q;
    assign phase_o      = phase_q;
    assign playing_o    = playing_q;
    assign game_over_o  = over_q;
    assign hit_accept_o = hit_accept_q;

endmodule

// File: tb/tb_round_controller.sv
// Two controllers (score limits 99 and 10) share one stimulus stream and are
// compared every frame against a rule-level model, plus directed scenario checks.
module tb_round_controller;

    localparam int RF = 4, RO = 20, MH = 3, LV = 2, BON = 5;
    localparam int P_IDLE = 0, P_READY = 1, P_PLAY = 2, P_HOLD = 3, P_OVER = 4;

    logic clk = 1'b0, rst = 1'b0, clr = 1'b0, run = 1'b0, pau = 1'b0, hit = 1'b0, flr = 1'b0;

    logic [10:0] score_w [2];
    logic [3:0]  hlo_w [2];
    logic [3:0]  hhi_w [2];
    logic [2:0]  lives_w [2];
    logic [11:0] tl_w [2];
    logic [2:0]  phase_w [2];
    logic        play_w [2];
    logic        over_w [2];
    logic        acc_w [2];

    int m_ph [2], m_sc [2], m_lv [2], m_tl [2], m_pt [2];
    bit m_prev_hit [2], m_prev_flr [2], m_acc [2];
    int acc_cnt [2];
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    round_controller #(
        .READY_FRAMES(RF), .ROUND_FRAMES(RO), .MISS_HOLD_FRAMES(MH), .LIVES(LV),
        .SCORE_MAX(99), .TIME_BONUS_FRAMES(BON)
    ) dut (
        .frame_clk_i(clk), .reset_i(rst), .clear_i(clr), .run_i(run), .pause_i(pau),
        .hit_target_i(hit), .hit_floor_i(flr),
        .score_o(score_w[0]), .hex_lo_o(hlo_w[0]), .hex_hi_o(hhi_w[0]), .lives_o(lives_w[0]),
        .time_left_o(tl_w[0]), .phase_o(phase_w[0]), .playing_o(play_w[0]),
        .game_over_o(over_w[0]), .hit_accept_o(acc_w[0])
    );

    round_controller #(
        .READY_FRAMES(RF), .ROUND_FRAMES(RO), .MISS_HOLD_FRAMES(MH), .LIVES(LV),
        .SCORE_MAX(10), .TIME_BONUS_FRAMES(BON)
    ) dut_sat (
        .frame_clk_i(clk), .reset_i(rst), .clear_i(clr), .run_i(run), .pause_i(pau),
        .hit_target_i(hit), .hit_floor_i(flr),
        .score_o(score_w[1]), .hex_lo_o(hlo_w[1]), .hex_hi_o(hhi_w[1]), .lives_o(lives_w[1]),
        .time_left_o(tl_w[1]), .phase_o(phase_w[1]), .playing_o(play_w[1]),
        .game_over_o(over_w[1]), .hit_accept_o(acc_w[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = P_IDLE; m_sc[k] = 0; m_lv[k] = 0; m_tl[k] = 0; m_pt[k] = 0;
            m_prev_hit[k] = 0; m_prev_flr[k] = 0; m_acc[k] = 0;
        end
    endtask

    // One frame of the game rules for unit k, using the inputs present at the edge.
    task automatic model_step(input int k);
        bit he, me, over;
        int smax;
        smax = (k == 0) ? 99 : 10;
        if (rst) begin
            m_ph[k] = P_IDLE; m_sc[k] = 0; m_lv[k] = 0; m_tl[k] = 0; m_pt[k] = 0;
            m_prev_hit[k] = 0; m_prev_flr[k] = 0; m_acc[k] = 0;
            return;
        end
        he = hit && !m_prev_hit[k];
        me = flr && !m_prev_flr[k];
        m_prev_hit[k] = hit;
        m_prev_flr[k] = flr;
        m_acc[k] = 0;
        if (clr) begin
            m_ph[k] = P_IDLE; m_sc[k] = 0; m_lv[k] = 0; m_tl[k] = 0; m_pt[k] = 0;
            return;
        end
        if (pau) return;
        if (!run && m_ph[k] != P_IDLE) begin
            m_ph[k] = P_IDLE;
            return;
        end
        if (m_ph[k] == P_IDLE) begin
            if (run) begin m_ph[k] = P_READY; m_pt[k] = RF; m_lv[k] = LV; end
        end else if (m_ph[k] == P_READY || m_ph[k] == P_HOLD) begin
            m_pt[k]--;
            if (m_pt[k] == 0) begin
                if (m_ph[k] == P_READY) m_tl[k] = RO;
                m_ph[k] = P_PLAY;
            end
        end else if (m_ph[k] == P_PLAY) begin
            if (he && m_sc[k] < smax) begin m_sc[k]++; m_acc[k] = 1; end
            m_tl[k]--;
            over = (m_tl[k] == 0) || (me && m_lv[k] == 1);
            if (me) m_lv[k]--;
            if (over) m_ph[k] = P_OVER;
            else if (me) begin m_ph[k] = P_HOLD; m_pt[k] = MH; end
`ifdef ROUND_TIME_BONUS_EN
            if (m_acc[k] && !over) m_tl[k] = (m_tl[k] + BON > RO) ? RO : m_tl[k] + BON;
`endif
        end
    endtask

    task automatic cmp_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d.score", k), 32'(score_w[k]), m_sc[k]);
            check($sformatf("u%0d.hex_lo", k), 32'(hlo_w[k]), m_sc[k] % 10);
            check($sformatf("u%0d.hex_hi", k), 32'(hhi_w[k]), m_sc[k] / 10);
            check($sformatf("u%0d.lives", k), 32'(lives_w[k]), m_lv[k]);
            check($sformatf("u%0d.time_left", k), 32'(tl_w[k]), m_tl[k]);
            check($sformatf("u%0d.phase", k), 32'(phase_w[k]), m_ph[k]);
            check($sformatf("u%0d.playing", k), 32'(play_w[k]), 32'(m_ph[k] == P_PLAY));
            check($sformatf("u%0d.game_over", k), 32'(over_w[k]), 32'(m_ph[k] == P_OVER));
            check($sformatf("u%0d.hit_accept", k), 32'(acc_w[k]), 32'(m_acc[k]));
            if (acc_w[k] === 1'b1) acc_cnt[k]++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        cmp_all();
    endtask

    task automatic hit_pulse();
        hit = 1'b1; tick();
        hit = 1'b0; tick();
    endtask

    task automatic start_round();
        run = 1'b0; tick();
        run = 1'b1; tick();
        check("round.ready", 32'(phase_w[0]), P_READY);
        repeat (RF) tick();
        check("round.play", 32'(phase_w[0]), P_PLAY);
        check("round.tl", 32'(tl_w[0]), RO);
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        #1 cmp_all();
        tick();
        rst = 1'b0;

        // Reach PLAY, score 5, then reset asynchronously in the middle of a frame.
        run = 1'b1; tick();
        repeat (RF) tick();
        repeat (5) hit_pulse();
        check("pre_rst.score", 32'(score_w[0]), 5);
        #2 rst = 1'b1;
        #1 model_reset();
        check("async.phase", 32'(phase_w[0]), P_IDLE);
        check("async.score", 32'(score_w[0]), 0);
        check("async.tl", 32'(tl_w[0]), 0);
        cmp_all();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst.ready", 32'(phase_w[0]), P_READY);
        repeat (RF - 1) tick();
        check("post_rst.still_ready", 32'(phase_w[0]), P_READY);
        tick();
        check("post_rst.play", 32'(phase_w[0]), P_PLAY);
        check("post_rst.tl", 32'(tl_w[0]), RO);

        // Twelve hits over two rounds; the score carries across the restart.
        acc_cnt[0] = 0; acc_cnt[1] = 0;
        repeat (7) hit_pulse();
        start_round();
        repeat (5) hit_pulse();
        check("hits.score", 32'(score_w[0]), 12);
        check("hits.hex_hi", 32'(hhi_w[0]), 1);
        check("hits.hex_lo", 32'(hlo_w[0]), 2);
        check("hits.accepts", 32'(acc_cnt[0]), 12);
        check("sat.score", 32'(score_w[1]), 10);
        check("sat.accepts", 32'(acc_cnt[1]), 10);
        pau = 1'b1; tick();
        hit = 1'b1; repeat (5) tick();
        pau = 1'b0; repeat (2) tick();
        hit = 1'b0; tick();
        check("pause_hit.score", 32'(score_w[0]), 12);
        check("pause_hit.tl", 32'(tl_w[0]), 7);

        // Miss handling: one life lost and hold-off, then the last life.
        start_round();
        flr = 1'b1; tick();
        flr = 1'b0;
        check("miss1.phase", 32'(phase_w[0]), P_HOLD);
        check("miss1.lives", 32'(lives_w[0]), 1);
        repeat (MH - 1) tick();
        check("hold.phase", 32'(phase_w[0]), P_HOLD);
        check("hold.tl", 32'(tl_w[0]), RO - 1);
        tick();
        check("hold.done", 32'(phase_w[0]), P_PLAY);
        check("hold.tl_frozen", 32'(tl_w[0]), RO - 1);
        flr = 1'b1; tick();
        flr = 1'b0;
        check("miss2.phase", 32'(phase_w[0]), P_OVER);
        check("miss2.lives", 32'(lives_w[0]), 0);

        // Expiry with a hit on the final tick.
        start_round();
        repeat (RO - 1) tick();
        check("expiry.tl1", 32'(tl_w[0]), 1);
        hit = 1'b1; tick();
        hit = 1'b0;
        check("expiry.phase", 32'(phase_w[0]), P_OVER);
        check("expiry.tl0", 32'(tl_w[0]), 0);
        check("expiry.score", 32'(score_w[0]), 13);
        check("expiry.accept", 32'(acc_w[0]), 1);
        tick();

        clr = 1'b1; tick();
        clr = 1'b0;
        check("clear.phase", 32'(phase_w[0]), P_IDLE);
        check("clear.score", 32'(score_w[0]), 0);
        check("clear.hex_hi", 32'(hhi_w[0]), 0);

`ifdef ROUND_TIME_BONUS_EN
        start_round();
        repeat (2) tick();
        hit = 1'b1; tick();
        hit = 1'b0;
        check("bonus.tl", 32'(tl_w[0]), RO);
        tick();
`endif

        // Randomized play against the model.
        run = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            run = ($urandom_range(99) < 96);
            pau = ($urandom_range(99) < 10);
            hit = 1'($urandom_range(1));
            flr = ($urandom_range(99) < 8);
            clr = ($urandom_range(999) < 5);
            tick();
        end
        clr = 1'b0; pau = 1'b0; hit = 1'b0; flr = 1'b0; run = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
